uart_cmd_dispatcher: RTL and testbench

//  Command stage between uart_top RX frame output and the AES cipher core.

---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_cmd_dispatcher_if.sv | 36 +++
 rtl/uart_cmd_dispatcher.sv | 134 +++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command dispatcher: opcodes, frame
// geometry, FSM encoding and a frame-building helper.
package uart_cmd_pkg;

   localparam int FRAME_BYTES = 18;
   localparam int FRAME_W     = 8 * FRAME_BYTES;
   localparam int PAY_W       = 128;

   localparam logic [7:0] OP_KEY  = 8'h43;
   localparam logic [7:0] OP_TEXT = 8'h44;
   localparam logic [7:0] OP_ENC  = 8'h45;
   localparam logic [7:0] OP_RES  = 8'h40;
   localparam logic [7:0] OP_RKEY = 8'h61;
   localparam logic [7:0] OP_RTXT = 8'h62;
   localparam logic [7:0] OP_PING = 8'h41;
   localparam logic [7:0] OP_NAK  = 8'h3F;
   localparam logic [7:0] OP_TMO  = 8'h54;

   localparam logic [PAY_W-1:0] PING_PAT =
      128'h0123456789ABCDEF0123456789ABCDEF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WAIT_AES,
      ST_RESP
   } state_t;

   // Opcode sits in the low byte, trailer repeats it in the top byte.
   function automatic logic [FRAME_W-1:0] mk_frame(
      input logic [7:0]       op,
      input logic [PAY_W-1:0] pay
   );
      return {op, pay, op};
   endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_if.sv
// Frame, AES and TX handshake bundle between the dispatcher and its
// neighbours (RX FIFO, AES core, UART TX).
interface uart_cmd_dispatcher_if #(
   parameter int FW     = 144,
   parameter int DATA_W = 128
);

   logic              frame_valid;
   logic [FW-1:0]     frame_data;
   logic              frame_pop;
   logic [DATA_W-1:0] aes_key;
   logic [DATA_W-1:0] aes_text;
   logic              aes_ld;
   logic              aes_done;
   logic [DATA_W-1:0] aes_result;
   logic [FW-1:0]     tx_data;
   logic              tx_send;
   logic              tx_busy;
   logic [7:0]        err_count;
   logic              busy;

   modport slave (
      input  frame_valid, frame_data,
      input  aes_done, aes_result, tx_busy,
      output frame_pop, aes_key, aes_text, aes_ld,
      output tx_data, tx_send, err_count, busy
   );

   modport master (
      output frame_valid, frame_data,
      output aes_done, aes_result, tx_busy,
      input  frame_pop, aes_key, aes_text, aes_ld,
      input  tx_data, tx_send, err_count, busy
   );

endinterface

// File: rtl/uart_cmd_dispatcher.sv
// Command stage between the UART RX frame FIFO and the AES core: decodes
// 18-byte frames, owns key/text/result registers and builds TX replies.
module uart_cmd_dispatcher
   import uart_cmd_pkg::*;
#(
   parameter int                FRAME_BYTES    = 18,
   parameter int                DATA_W         = 128,
   parameter int                TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] KEY_INIT       = '0,
   parameter logic [DATA_W-1:0] TEXT_INIT      = '0
) (
   input logic clk,
   input logic reset,
   uart_cmd_dispatcher_if.slave bus
);

   localparam int FW = 8 * FRAME_BYTES;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   logic [FW-1:0]     r_frame;
   logic [DATA_W-1:0] r_key;
   logic [DATA_W-1:0] r_text;
   logic [DATA_W-1:0] r_result;
   logic [FW-1:0]     r_tx_data;
   logic              r_pop;
   logic              r_ld;
   logic              r_send;
   logic [7:0]        r_err;
   logic [TW-1:0]     r_timer;

   logic [7:0]        w_op;
   logic [7:0]        w_trl;
   logic [DATA_W-1:0] w_pay;
   logic              w_match;

   assign w_op    = r_frame[7:0];
   assign w_trl   = r_frame[FW-1 -: 8];
   assign w_pay   = r_frame[DATA_W+7:8];
   assign w_match = (w_op == w_trl);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_frame   <= '0;
         r_key     <= KEY_INIT;
         r_text    <= TEXT_INIT;
         r_result  <= '0;
         r_tx_data <= '0;
         r_pop     <= 1'b0;
         r_ld      <= 1'b0;
         r_send    <= 1'b0;
         r_err     <= '0;
         r_timer   <= '0;
      end else begin
         r_pop  <= 1'b0;
         r_ld   <= 1'b0;
         r_send <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (bus.frame_valid) begin
                  r_frame <= bus.frame_data;
                  r_pop   <= 1'b1;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (!w_match) begin
                  if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_RESP;
                  unique case (1'b1)
                     (w_op == OP_KEY): begin
                        r_key     <= w_pay;
                        r_tx_data <= {OP_KEY, w_pay, OP_KEY};
                     end
                     (w_op == OP_TEXT): begin
                        r_text    <= w_pay;
                        r_tx_data <= {OP_TEXT, w_pay, OP_TEXT};
                     end
                     (w_op == OP_ENC): begin
                        r_ld    <= 1'b1;
                        r_timer <= '0;
                        r_state <= ST_WAIT_AES;
                     end
                     (w_op == OP_RES):
                        r_tx_data <= {OP_RES, r_result, OP_RES};
                     (w_op == OP_RKEY):
                        r_tx_data <= {OP_RKEY, r_key, OP_RKEY};
                     (w_op == OP_RTXT):
                        r_tx_data <= {OP_RTXT, r_text, OP_RTXT};
                     (w_op == OP_PING):
                        r_tx_data <= {OP_PING, DATA_W'(PING_PAT), OP_PING};
                     default:
                        r_tx_data <= {OP_NAK, {DATA_W{1'b0}}, OP_NAK};
                  endcase
               end
            end
            ST_WAIT_AES: begin
               // A done arriving on the final timer cycle still counts.
               if (bus.aes_done) begin
                  r_result  <= bus.aes_result;
                  r_tx_data <= {OP_RES, bus.aes_result, OP_RES};
                  r_state   <= ST_RESP;
               end else if (r_timer == T_LAST) begin
                  r_tx_data <= {OP_TMO, {DATA_W{1'b0}}, OP_TMO};
                  r_state   <= ST_RESP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            ST_RESP: begin
               if (!bus.tx_busy) begin
                  r_send  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.frame_pop = r_pop;
   assign bus.aes_key   = r_key;
   assign bus.aes_text  = r_text;
   assign bus.aes_ld    = r_ld;
   assign bus.tx_data   = r_tx_data;
   assign bus.tx_send   = r_send;
   assign bus.err_count = r_err;
   assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Scoreboard bench for uart_cmd_dispatcher: directed frames in, expected
// replies queued, a monitor checks each tx_send against the queue.
module tb_uart_cmd_dispatcher;
   import uart_cmd_pkg::*;

   localparam int TMO = 16;
   localparam logic [PAY_W-1:0] K  = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [PAY_W-1:0] K2 = 128'hFFEEDDCCBBAA99887766554433221100;
   localparam logic [PAY_W-1:0] T1 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [PAY_W-1:0] R  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
   localparam logic [PAY_W-1:0] R2 = 128'hDEADBEEF0000111122223333CAFEF00D;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_cmd_dispatcher_if #(.FW(FRAME_W), .DATA_W(PAY_W)) bus ();

   uart_cmd_dispatcher #(.TIMEOUT_CYCLES(TMO)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [FRAME_W-1:0] rxq[$];
   logic [FRAME_W-1:0] exp_q[$];
   int n_cmp = 0, n_err = 0;
   int n_pop = 0, n_send = 0, n_ld = 0;
   int pop_cyc = 0, send_cyc = 0, ld_cyc = 0;
   int cyc = 0;
   bit aes_en = 1'b0;
   int aes_delay = 16;
   logic [PAY_W-1:0] aes_val = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [FRAME_W-1:0] act,
                        input logic [FRAME_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input string nm, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         ok = (rxq.size() == 0) && (exp_q.size() == 0) &&
              !bus.busy && !bus.frame_pop;
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL %s: timeout after %0d cycles", nm, budget);
      end
   endtask

   // RX FIFO model: head frame presented, popped on frame_pop.
   initial begin
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.frame_pop) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            n_pop++;
            pop_cyc = cyc;
         end
         bus.frame_valid = (rxq.size() != 0);
         bus.frame_data  = (rxq.size() != 0) ? rxq[0] : '0;
      end
   end

   // AES core model: done pulse aes_delay cycles after aes_ld.
   initial begin
      bus.aes_done   = 1'b0;
      bus.aes_result = '0;
      forever begin
         @(negedge clk);
         if (bus.aes_ld && aes_en) begin
            repeat (aes_delay - 1) @(negedge clk);
            bus.aes_done   = 1'b1;
            bus.aes_result = aes_val;
            @(negedge clk);
            bus.aes_done   = 1'b0;
         end
      end
   end

   // Monitor: every tx_send must match the next expected reply.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.aes_ld) begin
            n_ld++;
            ld_cyc = cyc;
         end
         if (bus.tx_send) begin
            n_send++;
            send_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_tx: got %h expected none", bus.tx_data);
            end else begin
               check("tx_frame", bus.tx_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, s0, l0, s1;
      bus.tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_key", FRAME_W'(bus.aes_key), '0);
      check("rst_text", FRAME_W'(bus.aes_text), '0);
      check("rst_tx_data", bus.tx_data, '0);
      check("rst_err", FRAME_W'(bus.err_count), '0);
      check("rst_pulses", FRAME_W'({bus.frame_pop, bus.aes_ld, bus.tx_send, bus.busy}), '0);

      // key load, write latency
      exp_q.push_back(mk_frame(OP_KEY, K));
      rxq.push_back(mk_frame(OP_KEY, K));
      wait_idle("t1_idle", 40);
      check("t1_key", FRAME_W'(bus.aes_key), FRAME_W'(K));
      check("t1_pops", FRAME_W'(n_pop), 1);
      check("t1_sends", FRAME_W'(n_send), 1);
      check("t1_latency", FRAME_W'(send_cyc - pop_cyc), 2);

      // text load, read-backs, ping, unknown opcode
      exp_q.push_back(mk_frame(OP_TEXT, T1));
      rxq.push_back(mk_frame(OP_TEXT, T1));
      exp_q.push_back(mk_frame(OP_RKEY, K));
      rxq.push_back(mk_frame(OP_RKEY, K2));
      exp_q.push_back(mk_frame(OP_RTXT, T1));
      rxq.push_back(mk_frame(OP_RTXT, '0));
      exp_q.push_back(mk_frame(OP_PING, PING_PAT));
      rxq.push_back(mk_frame(OP_PING, '0));
      exp_q.push_back(mk_frame(OP_NAK, '0));
      rxq.push_back(mk_frame(8'h5A, K));
      wait_idle("rd_idle", 100);
      check("rd_text", FRAME_W'(bus.aes_text), FRAME_W'(T1));

      // encryption, done on the final timer cycle wins over timeout
      aes_en = 1'b1; aes_delay = TMO; aes_val = R;
      p0 = n_pop; l0 = n_ld;
      exp_q.push_back(mk_frame(OP_RES, R));
      rxq.push_back(mk_frame(OP_ENC, K2));
      wait_idle("t2_idle", 80);
      check("t2_ld_cnt", FRAME_W'(n_ld - l0), 1);
      check("t2_ld_lat", FRAME_W'(ld_cyc - pop_cyc), 1);
      exp_q.push_back(mk_frame(OP_RES, R));
      rxq.push_back(mk_frame(OP_RES, '0));
      wait_idle("t2_rd", 40);

      // early done
      aes_delay = 5; aes_val = R2;
      exp_q.push_back(mk_frame(OP_RES, R2));
      rxq.push_back(mk_frame(OP_ENC, '0));
      wait_idle("t2b_idle", 80);

      // trailer mismatch then saturation
      s0 = n_send;
      rxq.push_back({8'h58, K2, OP_KEY});
      wait_idle("t3_idle", 40);
      check("t3_err1", FRAME_W'(bus.err_count), 1);
      check("t3_key_kept", FRAME_W'(bus.aes_key), FRAME_W'(K));
      for (int i = 0; i < 300; i++)
         rxq.push_back({8'h59, PAY_W'(i), 8'h58});
      wait_idle("t3_sat", 1000);
      check("t3_err_sat", FRAME_W'(bus.err_count), 255);
      check("t3_no_tx", FRAME_W'(n_send - s0), 0);

      // timeout: T frame loaded TMO cycles after aes_ld, sent next cycle
      aes_en = 1'b0;
      exp_q.push_back(mk_frame(OP_TMO, '0));
      rxq.push_back(mk_frame(OP_ENC, '0));
      wait_idle("t4_idle", 80);
      check("t4_lat", FRAME_W'(send_cyc - ld_cyc), TMO + 1);
      exp_q.push_back(mk_frame(OP_PING, PING_PAT));
      rxq.push_back(mk_frame(OP_PING, '0));
      wait_idle("t4_next", 40);

      // back-pressure from TX
      bus.tx_busy = 1'b1;
      p0 = n_pop; s0 = n_send;
      exp_q.push_back(mk_frame(OP_RKEY, K));
      rxq.push_back(mk_frame(OP_RKEY, '0));
      exp_q.push_back(mk_frame(OP_RTXT, T1));
      rxq.push_back(mk_frame(OP_RTXT, '0));
      repeat (50) @(negedge clk);
      #1;
      check("t5_pop_held", FRAME_W'(n_pop - p0), 1);
      check("t5_send_held", FRAME_W'(n_send - s0), 0);
      bus.tx_busy = 1'b0;
      s1 = -1;
      for (int i = 0; i < 20 && s1 < 0; i++) begin
         @(negedge clk); #1;
         if (n_send - s0 >= 1) s1 = send_cyc;
      end
      wait_idle("t5_idle", 40);
      check("t5_pops", FRAME_W'(n_pop - p0), 2);
      check("t5_sends", FRAME_W'(n_send - s0), 2);
      check("t5_order", FRAME_W'(s1 >= 0 && pop_cyc > s1), 1);

      // reset during WAIT_AES, late done must be ignored
      aes_en = 1'b1; aes_delay = 10; aes_val = R2;
      l0 = n_ld;
      rxq.push_back(mk_frame(OP_ENC, '0));
      for (int i = 0; i < 20 && n_ld == l0; i++) @(negedge clk);
      check("t6_ld_seen", FRAME_W'(n_ld - l0), 1);
      repeat (3) @(negedge clk);
      s0 = n_send;
      reset = 1'b1;
      #1;
      check("t6_busy", FRAME_W'(bus.busy), 0);
      check("t6_key", FRAME_W'(bus.aes_key), '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("t6_no_tx", FRAME_W'(n_send - s0), 0);
      aes_en = 1'b0;
      exp_q.push_back(mk_frame(OP_RES, '0));
      rxq.push_back(mk_frame(OP_RES, '0));
      wait_idle("t6_res", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
